// File: rtl/parking_occupancy_ctrl.sv
// ---------------------------------------------------------------------------
// parking_occupancy_ctrl
//   Multi-lane parking occupancy tracker. Each raw beam sensor (active-low,
//   0 = car blocking the beam) is synchronised, debounced and passed through
//   a small block/clear FSM. A car is counted once, when it clears the beam.
//   The entry and exit events of one cycle are netted into a saturating
//   occupancy count. That count is compared against a capacity that can be
//   reloaded at run time.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   entry_n        raw entry beam sensors, asynchronous, 0 = blocked
//   exit_n         raw exit beam sensors, asynchronous, 0 = blocked
//   cap_in         new capacity value
//   cap_load       one-cycle strobe: capacity <= cap_in
//   clr_err        clears the sticky error flags
//   occupancy      cars currently inside
//   free_slots     capacity - occupancy, floored at 0
//   full           occupancy >= capacity
//   almost_full    free_slots <= ALMOST_THR
//   buzzer         same as full
//   underflow_err  sticky: an exit would have taken the count below 0
//   overflow_err   sticky: an entry would have taken the count above max
//   total_entries  (TOTAL_COUNT_EN only) lifetime entry count, mod 2^16
//
// Optional feature macro: TOTAL_COUNT_EN
// ---------------------------------------------------------------------------
module parking_occupancy_ctrl #(
  parameter int NUM_LANES    = 2,
  parameter int CNT_W        = 8,
  parameter int DEBOUNCE_CYC = 16,
  parameter int DEFAULT_CAP  = 10,
  parameter int ALMOST_THR   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] entry_n,
  input  logic [NUM_LANES-1:0] exit_n,
  input  logic [CNT_W-1:0]     cap_in,
  input  logic                 cap_load,
  input  logic                 clr_err,
  output logic [CNT_W-1:0]     occupancy,
  output logic [CNT_W-1:0]     free_slots,
  output logic                 full,
  output logic                 almost_full,
  output logic                 buzzer,
  output logic                 underflow_err,
  output logic                 overflow_err
`ifdef TOTAL_COUNT_EN
  ,
  output logic [15:0]          total_entries
`endif
);

  localparam int NS  = 2 * NUM_LANES;
  localparam int DCW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int SW  = CNT_W + 5;
  localparam logic [DCW-1:0]   DEB_LAST = DCW'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CAP_RST  = CNT_W'(DEFAULT_CAP);
  localparam logic [CNT_W:0]   ALMOST_V = (CNT_W + 1)'(ALMOST_THR);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_BLOCKED = 1'b1
  } sens_state_e;

  // Number of set bits in a lane vector.
  function automatic logic [3:0] popcnt(input logic [NUM_LANES-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // Entry sensors occupy the low half, exit sensors the high half.
  logic [NS-1:0] raw_s;
  logic [NS-1:0] pulse_s;

  assign raw_s = {exit_n, entry_n};

  for (genvar g = 0; g < NS; g++) begin : g_sensor
    logic           sync1_q, sync2_q;
    logic           deb_q, deb_d;
    logic [DCW-1:0] cnt_q, cnt_d;
    sens_state_e    state_q, state_d;
    logic           event_q, event_d;

    // Synchroniser, debounce and block/clear FSM registers.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        deb_q   <= 1'b1;
        cnt_q   <= '0;
        state_q <= S_IDLE;
        event_q <= 1'b0;
      end else begin
        sync1_q <= raw_s[g];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
        state_q <= state_d;
        event_q <= event_d;
      end
    end

    // The debounce counter runs only while the synced level disagrees with the
    // debounced level. The level flips on the DEBOUNCE_CYC-th disagreeing cycle.
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == DEB_LAST) begin
          deb_d = sync2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + {{(DCW-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_d = '0;
      end
    end

    // Block/clear FSM. An event fires only when a blocked beam clears.
    always_comb begin
      state_d = state_q;
      event_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!deb_q) begin
            state_d = S_BLOCKED;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BLOCKED: begin
          if (deb_q) begin
            state_d = S_IDLE;
            event_d = 1'b1;
          end else begin
            state_d = S_BLOCKED;
          end
        end
        default: begin
          state_d = S_IDLE;
          event_d = 1'b0;
        end
      endcase
    end

    assign pulse_s[g] = event_q;
  end

  logic [CNT_W-1:0]     occupancy_q, occupancy_d;
  logic [CNT_W-1:0]     capacity_q, capacity_d;
  logic                 underflow_q, underflow_d;
  logic                 overflow_q, overflow_d;
  logic [3:0]           n_in_s, n_out_s;
  logic signed [SW-1:0] sum_s;
  logic [CNT_W-1:0]     free_s;

  // Occupancy, capacity and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occupancy_q <= '0;
      capacity_q  <= CAP_RST;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      occupancy_q <= occupancy_d;
      capacity_q  <= capacity_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  // Net this cycle's entries and exits, then saturate. The sum is wide enough
  // and signed, so the sign bit flags underflow and any bit above CNT_W flags overflow.
  always_comb begin
    n_in_s  = popcnt(pulse_s[NUM_LANES-1:0]);
    n_out_s = popcnt(pulse_s[NS-1:NUM_LANES]);
    sum_s   = $signed({5'd0, occupancy_q})
            + $signed({{(SW-4){1'b0}}, n_in_s})
            - $signed({{(SW-4){1'b0}}, n_out_s});
    occupancy_d = occupancy_q;
    // A new error wins over clr_err in the same cycle.
    underflow_d = underflow_q & ~clr_err;
    overflow_d  = overflow_q & ~clr_err;
    if (sum_s[SW-1]) begin
      occupancy_d = '0;
      underflow_d = 1'b1;
    end else if (sum_s[SW-2:CNT_W] != '0) begin
      occupancy_d = '1;
      overflow_d  = 1'b1;
    end else begin
      occupancy_d = sum_s[CNT_W-1:0];
    end
    if (cap_load) begin
      capacity_d = cap_in;
    end else begin
      capacity_d = capacity_q;
    end
  end

  // Free slots floor at zero when the capacity is below the occupancy.
  always_comb begin
    free_s = '0;
    if (capacity_q > occupancy_q) begin
      free_s = capacity_q - occupancy_q;
    end else begin
      free_s = '0;
    end
  end

  assign occupancy     = occupancy_q;
  assign free_slots    = free_s;
  assign full          = (occupancy_q >= capacity_q);
  assign almost_full   = ({1'b0, free_s} <= ALMOST_V);
  assign buzzer        = full;
  assign underflow_err = underflow_q;
  assign overflow_err  = overflow_q;

`ifdef TOTAL_COUNT_EN
  logic [15:0] total_q, total_d;

  // Lifetime entry count. Saturation and clr_err do not affect it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_q <= 16'd0;
    end else begin
      total_q <= total_d;
    end
  end

  // Wraps modulo 2^16.
  always_comb begin
    total_d = total_q + {12'd0, n_in_s};
  end

  assign total_entries = total_q;
`endif

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Self-checking bench for parking_occupancy_ctrl (NUM_LANES=2, CNT_W=8,
// DEBOUNCE_CYC=4, DEFAULT_CAP=10). The reference model tracks cars, capacity
// and error flags as plain integers and derives the status outputs arithmetically.
module tb_parking_occupancy_ctrl;
  localparam int NL   = 2;
  localparam int CW   = 8;
  localparam int DC   = 4;
  localparam int DCAP = 10;
  localparam int ATHR = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NL-1:0] entry_n, exit_n;
  logic [CW-1:0] cap_in;
  logic          cap_load, clr_err;
  logic [CW-1:0] occupancy, free_slots;
  logic          full, almost_full, buzzer, underflow_err, overflow_err;
`ifdef TOTAL_COUNT_EN
  logic [15:0]   total_entries;
`endif

  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   m_occ, m_cap, m_total;
  logic m_under, m_over;
  logic [20:0] dut_v;

  always #5 clk = ~clk;

  parking_occupancy_ctrl #(
    .NUM_LANES(NL), .CNT_W(CW), .DEBOUNCE_CYC(DC),
    .DEFAULT_CAP(DCAP), .ALMOST_THR(ATHR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .entry_n(entry_n), .exit_n(exit_n),
    .cap_in(cap_in), .cap_load(cap_load), .clr_err(clr_err),
    .occupancy(occupancy), .free_slots(free_slots), .full(full),
    .almost_full(almost_full), .buzzer(buzzer),
    .underflow_err(underflow_err), .overflow_err(overflow_err)
`ifdef TOTAL_COUNT_EN
    , .total_entries(total_entries)
`endif
  );

  assign dut_v = {occupancy, free_slots, full, almost_full, buzzer, underflow_err, overflow_err};

  function automatic void model_reset();
    m_occ = 0; m_cap = DCAP; m_under = 1'b0; m_over = 1'b0; m_total = 0;
  endfunction

  function automatic void model_apply(input int n_in, input int n_out);
    int s;
    s = m_occ + n_in - n_out;
    if (s < 0) begin
      m_occ = 0; m_under = 1'b1;
    end else if (s > 255) begin
      m_occ = 255; m_over = 1'b1;
    end else begin
      m_occ = s;
    end
    m_total = (m_total + n_in) % 65536;
  endfunction

  function automatic logic [20:0] model_vec();
    int f;
    f = (m_cap > m_occ) ? (m_cap - m_occ) : 0;
    return {8'(m_occ), 8'(f), 1'(m_occ >= m_cap), 1'(f <= ATHR), 1'(m_occ >= m_cap), m_under, m_over};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; entry_n = '1; exit_n = '1;
    cap_in = 8'd0; cap_load = 1'b0; clr_err = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  // Block the masked beams for hold cycles, release them and let the event settle.
  task automatic do_pass(input logic [1:0] en_m, input logic [1:0] ex_m, input int hold);
    entry_n = ~en_m; exit_n = ~ex_m;
    repeat (hold) tick();
    entry_n = '1; exit_n = '1;
    repeat (10) tick();
    model_apply($countones(en_m), $countones(ex_m));
  endtask

  // Short low pulse on one sensor (0,1 entry; 2,3 exit) that must be rejected.
  task automatic glitch(input int sel, input int len);
    if (sel < 2) entry_n[sel] = 1'b0;
    else exit_n[sel-2] = 1'b0;
    repeat (len) tick();
    entry_n = '1; exit_n = '1;
    repeat (DC + 4) tick();
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (dut_v !== {8'd0, 8'd10, 5'b00000}) begin
      bad_cnt++; $display("FAIL reset_state: got %h want %h", dut_v, {8'd0, 8'd10, 5'b00000});
    end
  endtask

  task automatic test_latency_glitch();
    logic [7:0] exp_o;
    do_reset();
    entry_n[0] = 1'b0;
    repeat (10) tick();
    entry_n[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_o = (i == 8) ? 8'd1 : 8'd0;
      total_cnt++;
      if (occupancy !== exp_o) begin
        bad_cnt++; $display("FAIL latency_cyc%0d: got %0d want %0d", i, occupancy, exp_o);
      end
    end
    model_apply(1, 0);
    glitch(1, 2);
    total_cnt++;
    if (dut_v !== model_vec()) begin
      bad_cnt++; $display("FAIL glitch_reject: got %h want %h", dut_v, model_vec());
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_o;
    do_reset();
    do_pass(2'b11, 2'b00, 10);
    do_pass(2'b11, 2'b00, 10);
    do_pass(2'b01, 2'b00, 10);
    entry_n = 2'b00; exit_n = 2'b10;
    repeat (10) tick();
    entry_n = '1; exit_n = '1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_o = (i == 8) ? 8'd6 : 8'd5;
      total_cnt++;
      if ({occupancy, underflow_err, overflow_err} !== {exp_o, 2'b00}) begin
        bad_cnt++; $display("FAIL net_step_cyc%0d: got %0d/%b%b want %0d/00", i, occupancy, underflow_err, overflow_err, exp_o);
      end
    end
    model_apply(2, 1);
    total_cnt++;
    if (dut_v !== model_vec()) begin
      bad_cnt++; $display("FAIL net_result: got %h want %h", dut_v, model_vec());
    end
  endtask

  task automatic test_full_almost();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      do_pass(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, 2'b00, $urandom_range(8, 14));
      total_cnt++;
      if (dut_v !== model_vec()) begin
        bad_cnt++; $display("FAIL fill_%0d: got %h want %h", k, dut_v, model_vec());
      end
      if (k == 8) begin
        total_cnt++;
        if ({almost_full, full} !== 2'b10) begin
          bad_cnt++; $display("FAIL almost_at8: got %b%b want 10", almost_full, full);
        end
      end
    end
    total_cnt++;
    if ({full, buzzer, free_slots} !== {2'b11, 8'd0}) begin
      bad_cnt++; $display("FAIL full_at10: got %b%b/%0d want 11/0", full, buzzer, free_slots);
    end
  endtask

  task automatic test_capacity_load();
    do_reset();
    repeat (3) do_pass(2'b11, 2'b00, 9);
    cap_in = 8'd4; cap_load = 1'b1; tick(); cap_load = 1'b0; m_cap = 4;
    total_cnt++;
    if ({full, free_slots, occupancy} !== {1'b1, 8'd0, 8'd6}) begin
      bad_cnt++; $display("FAIL cap4: got %b/%0d/%0d want 1/0/6", full, free_slots, occupancy);
    end
    cap_in = 8'd20; cap_load = 1'b1; tick(); cap_load = 1'b0; m_cap = 20;
    total_cnt++;
    if ({full, free_slots} !== {1'b0, 8'd14}) begin
      bad_cnt++; $display("FAIL cap20: got %b/%0d want 0/14", full, free_slots);
    end
    total_cnt++;
    if (dut_v !== model_vec()) begin
      bad_cnt++; $display("FAIL cap_model: got %h want %h", dut_v, model_vec());
    end
  endtask

  task automatic test_errors();
    logic [1:0] m;
    do_reset();
    do_pass(2'b00, 2'b01, 10);
    total_cnt++;
    if ({occupancy, underflow_err} !== {8'd0, 1'b1}) begin
      bad_cnt++; $display("FAIL underflow_set: got %0d/%b want 0/1", occupancy, underflow_err);
    end
    repeat (5) tick();
    total_cnt++;
    if (underflow_err !== 1'b1) begin
      bad_cnt++; $display("FAIL underflow_sticky: got %b want 1", underflow_err);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0; m_under = 1'b0;
    total_cnt++;
    if (underflow_err !== 1'b0) begin
      bad_cnt++; $display("FAIL underflow_clr: got %b want 0", underflow_err);
    end
    while (m_occ < 255) begin
      m = (m_occ <= 253) ? 2'($urandom_range(1, 3)) : 2'b01;
      do_pass(m, 2'b00, 8);
    end
    total_cnt++;
    if (dut_v !== model_vec()) begin
      bad_cnt++; $display("FAIL at255: got %h want %h", dut_v, model_vec());
    end
    do_pass(2'b01, 2'b00, 9);
    total_cnt++;
    if ({occupancy, overflow_err} !== {8'hFF, 1'b1}) begin
      bad_cnt++; $display("FAIL overflow_set: got %0d/%b want 255/1", occupancy, overflow_err);
    end
  endtask

  task automatic test_random_traffic();
    int r;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 5);
      if (r == 0) begin
        glitch($urandom_range(0, 3), $urandom_range(1, DC - 1));
      end else if (r == 1) begin
        cap_in = 8'($urandom_range(0, 30)); cap_load = 1'b1; tick(); cap_load = 1'b0;
        m_cap = int'(cap_in);
      end else if (r == 2) begin
        clr_err = 1'b1; tick(); clr_err = 1'b0; m_under = 1'b0; m_over = 1'b0;
      end else begin
        do_pass(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(8, 14));
      end
      total_cnt++;
      if (dut_v !== model_vec()) begin
        bad_cnt++; $display("FAIL random_%0d: got %h want %h", it, dut_v, model_vec());
      end
`ifdef TOTAL_COUNT_EN
      total_cnt++;
      if (total_entries !== 16'(m_total)) begin
        bad_cnt++; $display("FAIL random_total_%0d: got %0d want %0d", it, total_entries, m_total);
      end
`endif
    end
  endtask

  task automatic test_reset_blocked();
    do_reset();
    do_pass(2'b11, 2'b00, 10);
    entry_n[0] = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; entry_n = '1;
    model_reset();
    repeat (12) tick();
    total_cnt++;
    if (dut_v !== model_vec()) begin
      bad_cnt++; $display("FAIL reset_blocked: got %h want %h", dut_v, model_vec());
    end
`ifdef TOTAL_COUNT_EN
    do_pass(2'b01, 2'b00, 9);
    do_pass(2'b10, 2'b00, 9);
    do_pass(2'b01, 2'b00, 9);
    total_cnt++;
    if (total_entries !== 16'd3) begin
      bad_cnt++; $display("FAIL total_entries: got %0d want 3", total_entries);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_latency_glitch();
    test_simultaneous();
    test_full_almost();
    test_capacity_load();
    test_errors();
    test_random_traffic();
    test_reset_blocked();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
